// File: rtl/bft_stream_endpoint_if.sv
// Handshake/packet bundle between a BFT stream endpoint and its user.
// master = user/network side, slave = endpoint.
interface bft_stream_endpoint_if #(
   parameter int PACKET_BITS  = 49,
   parameter int PAYLOAD_BITS = 32,
   parameter int CREDIT_BITS  = 8
);
   logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
   logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
   logic [PAYLOAD_BITS-1:0] tx_data;
   logic                    tx_vld;
   logic                    tx_ack;
   logic [PAYLOAD_BITS-1:0] rx_data;
   logic                    rx_vld;
   logic                    rx_ack;
   logic                    resend;
   logic [CREDIT_BITS-1:0]  credit_cnt;
   logic                    rx_overflow;

   modport master (
      output din_leaf_bft2interface, tx_data, tx_vld,
      output rx_ack, resend,
      input  dout_leaf_interface2bft, tx_ack, rx_data,
      input  rx_vld, credit_cnt, rx_overflow
   );

   modport slave (
      input  din_leaf_bft2interface, tx_data, tx_vld,
      input  rx_ack, resend,
      output dout_leaf_interface2bft, tx_ack, rx_data,
      output rx_vld, credit_cnt, rx_overflow
   );
endinterface

// File: rtl/bft_stream_endpoint.sv
// BFT stream endpoint: ap_vld/ap_ack <-> 49-bit packets with credit flow control.
// Optional last-packet resend is built when BFT_EP_RESEND_EN is defined.
module bft_stream_endpoint #(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 4,
   parameter int NUM_PORT_BITS         = 4,
   parameter int DEST_LEAF             = 1,
   parameter int DEST_PORT             = 1,
   parameter int SELF_LEAF             = 0,
   parameter int SELF_PORT             = 1,
   parameter int RX_ADDR_BITS          = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64,
   parameter int CREDIT_BITS           = 8
) (
   input logic                  clk,
   input logic                  reset,
   bft_stream_endpoint_if.slave bus
);
   localparam int PB    = PAYLOAD_BITS;
   localparam int NLB   = NUM_LEAF_BITS;
   localparam int NPB   = NUM_PORT_BITS;
   localparam int AB    = RX_ADDR_BITS;
   localparam int DEPTH = 1 << AB;
   localparam int PCW   = $clog2(FREESPACE_UPDATE_SIZE + 1);
   localparam int CW    = CREDIT_BITS + 2;

   typedef enum logic {
      S_IDLE,
      S_ACK
   } state_e;

   logic [PACKET_BITS-1:0] din;
   logic                   in_vld;
   logic [NLB-1:0]         in_dleaf;
   logic [NPB-1:0]         in_dport;
   logic                   is_mine;
   logic                   is_ctrl;
   logic                   is_data;
   logic                   unused_src;

   assign din        = bus.din_leaf_bft2interface;
   assign in_vld     = din[PB+2*NPB+2*NLB];
   assign in_dleaf   = din[PB+2*NPB+NLB +: NLB];
   assign in_dport   = din[PB+NPB+NLB +: NPB];
   assign unused_src = ^din[PB +: NPB+NLB];
   assign is_mine    = in_vld && (in_dleaf == NLB'(SELF_LEAF));
   assign is_ctrl    = is_mine && (in_dport == '0);
   assign is_data    = is_mine && (in_dport == NPB'(SELF_PORT));

   // RX FIFO; the extra pointer MSB separates full from empty
   logic [AB:0]   wr_q, wr_d;
   logic [AB:0]   rd_q, rd_d;
   logic [PB-1:0] mem_q [DEPTH];
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          ovf_q, ovf_d;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AB] != rd_q[AB]) &&
                  (wr_q[AB-1:0] == rd_q[AB-1:0]);
   assign push  = is_data && !full;
   assign pop   = bus.rx_ack && !empty;
   assign wr_d  = push ? wr_q + (AB+1)'(1) : wr_q;
   assign rd_d  = pop ? rd_q + (AB+1)'(1) : rd_q;
   assign ovf_d = ovf_q | (is_data && full);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AB-1:0]] <= din[PB-1:0];
   end

   assign bus.rx_vld      = !empty;
   assign bus.rx_data     = empty ? '0 : mem_q[rd_q[AB-1:0]];
   assign bus.rx_overflow = ovf_q;

   logic [PCW-1:0] popcnt_q, popcnt_d;
   logic           thresh;
   logic           pend_q, pend_d;
   logic           pend_clr;

   always_comb begin
      popcnt_d = popcnt_q;
      thresh   = 1'b0;
      if (pop) begin
         if (popcnt_q == PCW'(FREESPACE_UPDATE_SIZE - 1)) begin
            popcnt_d = '0;
            thresh   = 1'b1;
         end else begin
            popcnt_d = popcnt_q + PCW'(1);
         end
      end
   end

   assign pend_d = (pend_q & ~pend_clr) | thresh;

   logic [PACKET_BITS-1:0] data_pkt;
   logic [PACKET_BITS-1:0] cred_pkt;

   assign data_pkt = {1'b1, NLB'(DEST_LEAF), NPB'(DEST_PORT),
                      NLB'(SELF_LEAF), NPB'(SELF_PORT), bus.tx_data};
   assign cred_pkt = {1'b1, NLB'(DEST_LEAF), {NPB{1'b0}},
                      NLB'(SELF_LEAF), NPB'(SELF_PORT),
                      PB'(FREESPACE_UPDATE_SIZE)};

`ifdef BFT_EP_RESEND_EN
   logic [PACKET_BITS-1:0] last_q;
   logic                   last_vld_q;
`else
   logic unused_resend;
   assign unused_resend = bus.resend;
`endif

   state_e                 state_q, state_d;
   logic [PACKET_BITS-1:0] dout_q, dout_d;
   logic                   ack_q, ack_d;
   logic                   dec;
   logic [CREDIT_BITS-1:0] credit_q, credit_d;

   // Credit packet wins over resend, which wins over new data
   always_comb begin
      state_d  = state_q;
      dout_d   = '0;
      ack_d    = 1'b0;
      dec      = 1'b0;
      pend_clr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               dout_d   = cred_pkt;
               pend_clr = 1'b1;
               state_d  = S_ACK;
            end
`ifdef BFT_EP_RESEND_EN
            else if (bus.resend && last_vld_q) begin
               dout_d  = last_q;
               state_d = S_ACK;
            end
`endif
            else if (bus.tx_vld && (credit_q != '0)) begin
               dout_d  = data_pkt;
               ack_d   = 1'b1;
               dec     = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   logic [CW-1:0] upd;
   logic [CW-1:0] csum;

   always_comb begin
      upd  = is_ctrl ? {2'b00, din[CREDIT_BITS-1:0]} : '0;
      csum = {2'b00, credit_q} + upd - CW'(dec);
      if (csum > {2'b00, {CREDIT_BITS{1'b1}}}) begin
         credit_d = '1;
      end else begin
         credit_d = csum[CREDIT_BITS-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         dout_q   <= '0;
         ack_q    <= 1'b0;
         credit_q <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         popcnt_q <= '0;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dout_q   <= dout_d;
         ack_q    <= ack_d;
         credit_q <= credit_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         popcnt_q <= popcnt_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef BFT_EP_RESEND_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else if (ack_d) begin
         last_q     <= data_pkt;
         last_vld_q <= 1'b1;
      end
   end
`endif

   assign bus.dout_leaf_interface2bft = dout_q;
   assign bus.tx_ack                  = ack_q;
   assign bus.credit_cnt              = credit_q;
endmodule

// File: tb/tb_bft_stream_endpoint.sv
// Directed self-checking bench for bft_stream_endpoint.
// Resend checks follow BFT_EP_RESEND_EN.
module tb_bft_stream_endpoint;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bft_stream_endpoint_if bus ();

   bft_stream_endpoint dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [48:0] mk(input logic [3:0] dl,
                                      input logic [3:0] dp,
                                      input logic [3:0] sl,
                                      input logic [3:0] sp,
                                      input logic [31:0] pl);
      return {1'b1, dl, dp, sl, sp, pl};
   endfunction

   task automatic inject(input logic [48:0] pkt);
      bus.din_leaf_bft2interface = pkt;
      @(negedge clk);
      bus.din_leaf_bft2interface = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Background watcher for the credit-return phase
   logic mon_en = 1'b0;
   int   ctrl_cnt = 0;
   int   ctrl_bad = 0;
   int   ack_cnt  = 0;
   logic [48:0] exp_ctrl;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.dout_leaf_interface2bft[48] &&
             bus.dout_leaf_interface2bft[43:40] == 4'd0) begin
            ctrl_cnt++;
            if (bus.dout_leaf_interface2bft != exp_ctrl || bus.tx_ack)
               ctrl_bad++;
         end
         if (bus.tx_ack) ack_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int nz, cnt, first, second, acks, errs;
      logic [48:0] got;
      exp_ctrl = mk(4'd1, 4'd0, 4'd0, 4'd1, 32'd64);
      bus.din_leaf_bft2interface = '0;
      bus.tx_data = '0;
      bus.tx_vld  = 1'b0;
      bus.rx_ack  = 1'b0;
      bus.resend  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_dout", bus.dout_leaf_interface2bft, 0);
      check("rst_ack", bus.tx_ack, 0);
      check("rst_rxvld", bus.rx_vld, 0);
      check("rst_rxdata", bus.rx_data, 0);
      check("rst_credit", bus.credit_cnt, 0);
      check("rst_ovf", bus.rx_overflow, 0);
      reset = 1'b1;
      @(negedge clk);

      // Credit gating
      bus.tx_data = 32'hA5A5A5A5;
      bus.tx_vld  = 1'b1;
      nz = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.tx_ack || bus.dout_leaf_interface2bft != '0) nz++;
      end
      check("gate_hold", nz, 0);
      inject(mk(4'd0, 4'd0, 4'd1, 4'd1, 32'd2));
      cnt = 0; first = -1; second = -1;
      for (int c = 0; c < 12; c++) begin
         if (bus.dout_leaf_interface2bft[48]) begin
            check("gate_pkt", bus.dout_leaf_interface2bft,
                  mk(4'd1, 4'd1, 4'd0, 4'd1, 32'hA5A5A5A5));
            check("gate_ack", bus.tx_ack, 1);
            if (cnt == 0) first = c;
            else second = c;
            cnt++;
         end
         @(negedge clk);
      end
      check("gate_count", cnt, 2);
      check("gate_gap", second - first, 2);
      check("gate_credit", bus.credit_cnt, 0);
      bus.tx_vld = 1'b0;

      // Packet format
      inject(mk(4'd0, 4'd0, 4'd1, 4'd1, 32'd1));
      bus.tx_data = 32'h12345678;
      bus.tx_vld  = 1'b1;
      cnt = 0; acks = 0; got = '0;
      repeat (6) begin
         @(negedge clk);
         if (bus.dout_leaf_interface2bft[48]) begin
            cnt++;
            got = bus.dout_leaf_interface2bft;
         end
         if (bus.tx_ack) acks++;
      end
      bus.tx_vld = 1'b0;
      check("fmt_pkt", got, 49'h1_1101_12345678);
      check("fmt_count", cnt, 1);
      check("fmt_acks", acks, 1);
      check("fmt_credit", bus.credit_cnt, 0);

      // RX path, foreign packets ignored first
      inject(mk(4'd2, 4'd1, 4'd3, 4'd2, 32'd99));
      inject(mk(4'd0, 4'd2, 4'd3, 4'd2, 32'd77));
      inject(mk(4'd3, 4'd0, 4'd3, 4'd2, 32'd5));
      check("ign_rxvld", bus.rx_vld, 0);
      check("ign_credit", bus.credit_cnt, 0);
      for (int i = 1; i <= 3; i++)
         inject(mk(4'd0, 4'd1, 4'd3, 4'd2, i));
      check("rx_vld0", bus.rx_vld, 1);
      check("rx_data0", bus.rx_data, 1);
      for (int k = 2; k <= 3; k++) begin
         bus.rx_ack = 1'b1;
         @(negedge clk);
         bus.rx_ack = 1'b0;
         check("rx_vldk", bus.rx_vld, 1);
         check("rx_datak", bus.rx_data, k);
      end
      bus.rx_ack = 1'b1;
      @(negedge clk);
      bus.rx_ack = 1'b0;
      check("rx_empty", bus.rx_vld, 0);

      // Credit return with data traffic competing
      do_reset();
      check("cr_rst_credit", bus.credit_cnt, 0);
      inject(mk(4'd0, 4'd0, 4'd1, 4'd1, 32'd255));
      check("cr_credit_load", bus.credit_cnt, 255);
      mon_en = 1'b1;
      @(negedge clk);
      bus.tx_data = 32'hC0FFEE00;
      bus.tx_vld  = 1'b1;
      errs = 0;
      for (int i = 1; i <= 64; i++) begin
         inject(mk(4'd0, 4'd1, 4'd3, 4'd2, i));
         if (!bus.rx_vld || bus.rx_data != i) errs++;
         bus.rx_ack = 1'b1;
         @(negedge clk);
         bus.rx_ack = 1'b0;
      end
      repeat (8) @(negedge clk);
      bus.tx_vld = 1'b0;
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      check("cr_rxdata", errs, 0);
      check("cr_ctrl_count", ctrl_cnt, 1);
      check("cr_ctrl_bad", ctrl_bad, 0);
      check("cr_tx_flow", ack_cnt > 0, 1);
      check("cr_credit", bus.credit_cnt, 255 - ack_cnt);

      // Overflow
      do_reset();
      for (int i = 1; i <= 128; i++) begin
         bus.din_leaf_bft2interface = mk(4'd0, 4'd1, 4'd3, 4'd2, i);
         @(negedge clk);
      end
      bus.din_leaf_bft2interface = '0;
      check("ovf_before", bus.rx_overflow, 0);
      inject(mk(4'd0, 4'd1, 4'd3, 4'd2, 32'd129));
      check("ovf_set", bus.rx_overflow, 1);
      errs = 0;
      bus.rx_ack = 1'b1;
      for (int i = 1; i <= 128; i++) begin
         if (!bus.rx_vld || bus.rx_data != i) errs++;
         @(negedge clk);
      end
      bus.rx_ack = 1'b0;
      check("ovf_contents", errs, 0);
      check("ovf_drained", bus.rx_vld, 0);
      check("ovf_sticky", bus.rx_overflow, 1);
      reset = 1'b0;
      #1;
      check("ovf_rst", bus.rx_overflow, 0);
      check("ovf_rst_vld", bus.rx_vld, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Resend
      bus.resend = 1'b1;
      @(negedge clk);
      bus.resend = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.dout_leaf_interface2bft != '0) cnt++;
      end
      check("rs_nothing", cnt, 0);
      inject(mk(4'd0, 4'd0, 4'd1, 4'd1, 32'd1));
      bus.tx_data = 32'hDEADBEEF;
      bus.tx_vld  = 1'b1;
      @(negedge clk);
      bus.tx_vld = 1'b0;
      check("rs_first", bus.dout_leaf_interface2bft,
            mk(4'd1, 4'd1, 4'd0, 4'd1, 32'hDEADBEEF));
      @(negedge clk);
      check("rs_credit0", bus.credit_cnt, 0);
      bus.resend = 1'b1;
      @(negedge clk);
      bus.resend = 1'b0;
`ifdef BFT_EP_RESEND_EN
      check("rs_pkt", bus.dout_leaf_interface2bft,
            mk(4'd1, 4'd1, 4'd0, 4'd1, 32'hDEADBEEF));
`else
      check("rs_ignored", bus.dout_leaf_interface2bft, 0);
`endif
      check("rs_noack", bus.tx_ack, 0);
      check("rs_credit", bus.credit_cnt, 0);
      @(negedge clk);
      check("rs_one_cycle", bus.dout_leaf_interface2bft, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
